// File: rtl/spi_resp_pkg.sv
// rtl/spi_resp_pkg.sv - shared constants and state encoding for the SPI mode-0 responder
package spi_resp_pkg;
   localparam int         SPI_BITS      = 8;
   localparam logic [7:0] IDLE_BYTE_DEF = 8'hFF;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;
endpackage

// File: rtl/spi_resp_sync.sv
// rtl/spi_resp_sync.sv - multi-bit synchroniser with registered rise/fall detection
module spi_resp_sync #(
   parameter int W      = 3,
   parameter int STAGES = 2
) (
   input  logic         fclk,
   input  logic         rst_n,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q,
   output logic [W-1:0] o_rise,
   output logic [W-1:0] o_fall
);
   logic [W-1:0] r_stg [STAGES];
   logic [W-1:0] r_last;
   logic [W-1:0] r_rise;
   logic [W-1:0] r_fall;

   // o_q is taken from the extra stage so levels line up with the registered edges
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) r_stg[i] <= '0;
         r_last <= '0;
         r_rise <= '0;
         r_fall <= '0;
      end else begin
         r_stg[0] <= i_d;
         for (int i = 1; i < STAGES; i++) r_stg[i] <= r_stg[i-1];
         r_last <= r_stg[STAGES-1];
         r_rise <= r_stg[STAGES-1] & ~r_last;
         r_fall <= ~r_stg[STAGES-1] & r_last;
      end
   end

   assign o_q    = r_last;
   assign o_rise = r_rise;
   assign o_fall = r_fall;
endmodule

// File: rtl/spi_resp.sv
// rtl/spi_resp.sv - SPI mode-0 slave responder with one-byte rx/tx holders
module spi_resp
   import spi_resp_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEF
) (
   input  logic                fclk,
   input  logic                rst_n,
   input  logic                spi_cs_n,
   input  logic                spi_sck,
   input  logic                spi_mosi,
   output logic                spi_miso,
   output logic                spi_miso_oe,
   output logic [SPI_BITS-1:0] rx_data,
   output logic                rx_valid,
   input  logic                rx_rd,
   input  logic [SPI_BITS-1:0] tx_data,
   input  logic                tx_wr,
   output logic                tx_empty,
   output logic                frame_end,
   output logic                overrun,
   output logic                underrun,
   input  logic                clr_flags
);
   logic [2:0]          w_q;
   logic [2:0]          w_rise;
   logic [2:0]          w_fall;
   logic                w_unused_sync;
   logic                w_start;
   logic                w_active;
   logic                w_reload;
   logic                w_load;
   logic                w_done;
   logic [SPI_BITS-1:0] w_load_byte;
   logic [SPI_BITS-1:0] w_rx_next;

   state_t              r_state;
   logic [2:0]          r_bit_cnt;
   logic                r_reload;
   logic                r_seen_rise;
   logic                r_armed;
   logic [SPI_BITS-1:0] r_rx_shift;
   logic [SPI_BITS-1:0] r_tx_shift;
   logic [SPI_BITS-1:0] r_hold;
   logic                r_tx_empty;
   logic [SPI_BITS-1:0] r_rx_data;
   logic                r_rx_valid;
   logic                r_overrun;
   logic                r_underrun;
   logic                r_frame_end;
   logic                r_miso;
   logic                r_miso_oe;

   spi_resp_sync #(.W(3), .STAGES(SYNC_STAGES)) u_sync (
      .fclk   (fclk),
      .rst_n  (rst_n),
      .i_d    ({spi_mosi, spi_sck, spi_cs_n}),
      .o_q    (w_q),
      .o_rise (w_rise),
      .o_fall (w_fall)
   );

   assign w_unused_sync = ^{w_q[1], w_rise[2], w_fall[2]};

   // a cs_n rise in the same cycle as an sck edge ends the frame and drops the edge
   assign w_start     = (r_state == ST_IDLE) && w_fall[0] && r_armed;
   assign w_active    = (r_state == ST_ACTIVE) && !w_rise[0];
   assign w_reload    = w_active && w_fall[1] && r_seen_rise && r_reload;
   assign w_load      = w_start || w_reload;
   assign w_load_byte = r_tx_empty ? IDLE_BYTE : r_hold;
   assign w_rx_next   = {r_rx_shift[SPI_BITS-2:0], w_q[2]};
   assign w_done      = w_active && w_rise[1] && (r_bit_cnt == 3'd7);

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_bit_cnt   <= 3'd0;
         r_reload    <= 1'b0;
         r_seen_rise <= 1'b0;
         r_armed     <= 1'b0;
         r_rx_shift  <= '0;
         r_tx_shift  <= '0;
         r_hold      <= '0;
         r_tx_empty  <= 1'b1;
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_overrun   <= 1'b0;
         r_underrun  <= 1'b0;
         r_frame_end <= 1'b0;
         r_miso      <= 1'b1;
         r_miso_oe   <= 1'b0;
      end else begin
         r_frame_end <= 1'b0;
         if (w_q[0]) r_armed <= 1'b1;
         if (rx_rd) r_rx_valid <= 1'b0;
         if (clr_flags) begin
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
         end
         if (w_load) begin
            r_tx_shift <= w_load_byte;
            r_miso     <= w_load_byte[SPI_BITS-1];
            if (r_tx_empty) r_underrun <= 1'b1;
            else            r_tx_empty <= 1'b1;
         end
         // a write in the load cycle lands in the holder after the load has used it
         if (tx_wr) begin
            r_hold     <= tx_data;
            r_tx_empty <= 1'b0;
         end
         if (w_done) begin
            r_rx_data  <= w_rx_next;
            r_rx_valid <= 1'b1;
            if (r_rx_valid && !rx_rd) r_overrun <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_state     <= ST_ACTIVE;
                  r_bit_cnt   <= 3'd0;
                  r_reload    <= 1'b0;
                  r_seen_rise <= 1'b0;
                  r_miso_oe   <= 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (w_rise[0]) begin
                  r_state     <= ST_IDLE;
                  r_bit_cnt   <= 3'd0;
                  r_reload    <= 1'b0;
                  r_miso_oe   <= 1'b0;
                  r_miso      <= 1'b1;
                  r_frame_end <= 1'b1;
               end else begin
                  if (w_rise[1]) begin
                     r_rx_shift  <= w_rx_next;
                     r_bit_cnt   <= r_bit_cnt + 3'd1;
                     r_seen_rise <= 1'b1;
                     if (r_bit_cnt == 3'd7) r_reload <= 1'b1;
                  end
                  if (w_fall[1] && r_seen_rise) begin
                     if (r_reload) begin
                        r_reload <= 1'b0;
                     end else begin
                        r_tx_shift <= {r_tx_shift[SPI_BITS-2:0], 1'b0};
                        r_miso     <= r_tx_shift[SPI_BITS-2];
                     end
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign spi_miso    = r_miso;
   assign spi_miso_oe = r_miso_oe;
   assign rx_data     = r_rx_data;
   assign rx_valid    = r_rx_valid;
   assign tx_empty    = r_tx_empty;
   assign frame_end   = r_frame_end;
   assign overrun     = r_overrun;
   assign underrun    = r_underrun;
endmodule

// File: tb/tb_spi_resp.sv
// tb/tb_spi_resp.sv - randomized SPI master bench with a byte-level holder/flag model
module tb_spi_resp;
   localparam int HALF = 8;

   logic       fclk      = 1'b0;
   logic       rst_n     = 1'b0;
   logic       spi_cs_n  = 1'b1;
   logic       spi_sck   = 1'b0;
   logic       spi_mosi  = 1'b0;
   logic       rx_rd     = 1'b0;
   logic       tx_wr     = 1'b0;
   logic       clr_flags = 1'b0;
   logic [7:0] tx_data   = 8'h00;
   logic       spi_miso, spi_miso_oe, rx_valid, tx_empty, frame_end, overrun, underrun;
   logic [7:0] rx_data;

   int n_chk = 0, n_fail = 0, fe_cnt = 0, fe_exp = 0;

   logic [7:0] m_hold, m_cur, m_rx_data;
   bit         m_empty, m_rx_valid, m_ovr, m_und;

   spi_resp #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
      .fclk(fclk), .rst_n(rst_n), .spi_cs_n(spi_cs_n), .spi_sck(spi_sck),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_rd(rx_rd), .tx_data(tx_data),
      .tx_wr(tx_wr), .tx_empty(tx_empty), .frame_end(frame_end),
      .overrun(overrun), .underrun(underrun), .clr_flags(clr_flags)
   );

   always #5 fclk = ~fclk;
   always @(posedge fclk) if (frame_end === 1'b1) fe_cnt++;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge fclk);
      #1;
   endtask

   task automatic m_reset();
      m_hold = 8'h00; m_cur = 8'hFF; m_rx_data = 8'h00;
      m_empty = 1; m_rx_valid = 0; m_ovr = 0; m_und = 0;
   endtask

   // byte boundary: holder contents if present, otherwise the idle byte and an underrun
   function automatic logic [7:0] m_load();
      if (m_empty) begin
         m_und = 1;
         return 8'hFF;
      end
      m_empty = 1;
      return m_hold;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_miso"}, spi_miso, 1);
      check({tag, "_oe"}, spi_miso_oe, 0);
      check({tag, "_rx_data"}, rx_data, 0);
      check({tag, "_rx_valid"}, rx_valid, 0);
      check({tag, "_tx_empty"}, tx_empty, 1);
      check({tag, "_frame_end"}, frame_end, 0);
      check({tag, "_overrun"}, overrun, 0);
      check({tag, "_underrun"}, underrun, 0);
   endtask

   task automatic check_state(input string tag);
      check({tag, "_rx_data"}, rx_data, m_rx_data);
      check({tag, "_rx_valid"}, rx_valid, m_rx_valid);
      check({tag, "_overrun"}, overrun, m_ovr);
      check({tag, "_underrun"}, underrun, m_und);
      check({tag, "_tx_empty"}, tx_empty, m_empty);
   endtask

   task automatic pulse_rd();
      rx_rd = 1; cyc(1); rx_rd = 0;
      m_rx_valid = 0;
   endtask

   task automatic write_tx(input logic [7:0] d);
      tx_data = d; tx_wr = 1; cyc(1); tx_wr = 0;
      m_hold = d; m_empty = 0;
   endtask

   task automatic clear_flags();
      clr_flags = 1; cyc(1); clr_flags = 0;
      m_ovr = 0; m_und = 0;
   endtask

   task automatic frame_start();
      spi_cs_n = 0;
      m_cur = m_load();
      cyc(HALF);
   endtask

   // cs_n rises together with the sck fall when the last byte held sck high
   task automatic frame_stop(input string tag);
      spi_cs_n = 1; spi_sck = 0;
      fe_exp++;
      cyc(HALF);
      check({tag, "_oe_idle"}, spi_miso_oe, 0);
      check({tag, "_miso_idle"}, spi_miso, 1);
      check({tag, "_frame_end_cnt"}, fe_cnt, fe_exp);
   endtask

   task automatic spi_byte(input string tag, input logic [7:0] mo, input bit rd_c,
                           input bit wr_c, input logic [7:0] wr_d, input bit hold);
      logic [7:0] mi;
      for (int i = 7; i >= 0; i--) begin
         spi_mosi = mo[i];
         cyc(HALF);
         spi_sck = 1;
         mi[i] = spi_miso;
         if (i == 0 && rd_c) begin
            cyc(3); rx_rd = 1; cyc(1); rx_rd = 0;
         end else begin
            cyc(4);
         end
         cyc(HALF - 4);
         if (!(i == 0 && hold)) spi_sck = 0;
      end
      check({tag, "_miso_byte"}, mi, m_cur);
      if (m_rx_valid && !rd_c) m_ovr = 1;
      m_rx_valid = 1;
      m_rx_data = mo;
      if (!hold) begin
         if (wr_c) begin
            tx_data = wr_d; cyc(3); tx_wr = 1; cyc(1); tx_wr = 0;
         end else begin
            cyc(4);
         end
         m_cur = m_load();
         if (wr_c) begin
            m_hold = wr_d; m_empty = 0;
         end
      end
      check_state(tag);
   endtask

   initial begin
      m_reset();
      cyc(3);
      check_reset_outputs("reset");
      rst_n = 1;
      cyc(6);

      // single byte, holder overwritten once before the frame
      write_tx(8'h5A);
      write_tx(8'hA5);
      frame_start();
      spi_byte("t1", 8'h3C, 0, 0, 8'h00, 1);
      frame_stop("t1");
      pulse_rd();

      // three bytes from an empty holder
      frame_start();
      spi_byte("t2b0", 8'h11, 0, 0, 8'h00, 0); pulse_rd();
      spi_byte("t2b1", 8'h22, 0, 0, 8'h00, 0); pulse_rd();
      spi_byte("t2b2", 8'h33, 0, 0, 8'h00, 1); pulse_rd();
      frame_stop("t2");
      clear_flags();

      // unread bytes overrun
      frame_start();
      spi_byte("t3b0", 8'h55, 0, 0, 8'h00, 0);
      spi_byte("t3b1", 8'hAA, 0, 0, 8'h00, 1);
      frame_stop("t3");
      clear_flags();
      check_state("t3_clr");
      pulse_rd();

      // aborted partial byte, then a full one
      frame_start();
      for (int i = 7; i >= 3; i--) begin
         spi_mosi = (8'hF0 >> i) & 1;
         cyc(HALF); spi_sck = 1; cyc(HALF); spi_sck = 0;
      end
      cyc(HALF);
      check("t4_oe_active", spi_miso_oe, 1);
      spi_cs_n = 1;
      fe_exp++;
      cyc(4);
      check("t4_oe_drop", spi_miso_oe, 0);
      check("t4_miso_drop", spi_miso, 1);
      cyc(HALF);
      check("t4_frame_end_cnt", fe_cnt, fe_exp);
      check_state("t4_partial");
      frame_start();
      spi_byte("t4", 8'h0F, 0, 0, 8'h00, 1);
      frame_stop("t4b");
      pulse_rd();
      clear_flags();

      // coincident rx_rd at completion and tx_wr at an empty reload
      frame_start();
      spi_byte("t5b0", 8'h01, 0, 0, 8'h00, 0);
      clear_flags();
      spi_byte("t5b1", 8'h02, 1, 1, 8'h77, 0);
      spi_byte("t5b2", 8'h03, 1, 0, 8'h00, 1);
      frame_stop("t5");
      pulse_rd();
      clear_flags();

      // reset mid-byte with cs_n held low
      frame_start();
      for (int i = 0; i < 3; i++) begin
         spi_mosi = i[0];
         cyc(HALF); spi_sck = 1; cyc(HALF); spi_sck = 0;
      end
      rst_n = 0;
      #1;
      check_reset_outputs("t6_rst");
      cyc(2);
      rst_n = 1;
      m_reset();
      cyc(6);
      for (int i = 0; i < 8; i++) begin
         spi_mosi = 1'($urandom_range(0, 1));
         cyc(HALF); spi_sck = 1; cyc(HALF); spi_sck = 0;
      end
      cyc(HALF);
      check_reset_outputs("t6_held");
      spi_cs_n = 1;
      cyc(HALF);
      frame_start();
      spi_byte("t6", 8'hC3, 0, 0, 8'h00, 1);
      frame_stop("t6");
      pulse_rd();

      // randomized frames
      for (int f = 0; f < 14; f++) begin
         int nb;
         if ($urandom_range(0, 1) == 1) write_tx(8'($urandom));
         nb = $urandom_range(1, 3);
         frame_start();
         for (int b = 0; b < nb; b++) begin
            bit last_hold;
            last_hold = (b == nb - 1) && ($urandom_range(0, 1) == 1);
            spi_byte("rnd", 8'($urandom), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) == 0), 8'($urandom), last_hold);
            if ($urandom_range(0, 1) == 1) pulse_rd();
            if ($urandom_range(0, 2) == 0) write_tx(8'($urandom));
         end
         frame_stop("rnd");
         if ($urandom_range(0, 2) == 0) clear_flags();
         check_state("rnd_end");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/spi_resp.md
Name: spi_resp

Overview:
SPI mode-0 slave responder in the fclk domain: the responding end of the byte-wise SPI master link (start/din/dout style) that the design uses toward serial devices.
- Oversamples an external master's cs_n/sck/mosi and deserialises MSB-first bytes into a one-byte receive holder with valid/ack.
- Serialises bytes from a one-byte transmit holder onto miso.
- Used for on-board device emulation and link loopback; a CPU port block or MCU-side logic drives the byte handshakes.

Parameters:
SYNC_STAGES, 2, synchroniser depth on cs_n/sck/mosi (min 2); edge detect uses one extra stage.
IDLE_BYTE, 8'hFF, byte shifted out when the transmit holder is empty at a byte boundary.

Ports:
fclk  in  1  system clock (only clock).
rst_n  in  1  asynchronous active-low reset.
spi_cs_n  in  1  master chip select, async.
spi_sck  in  1  master clock, async; idle low; high and low phases each >= 3 fclk.
spi_mosi  in  1  master data, async.
spi_miso  out  1  slave data.
spi_miso_oe  out  1  miso drive enable; the top level tri-states the pin.
rx_data  out  8  last received byte.
rx_valid  out  1  rx_data unread.
rx_rd  in  1  1-cycle acknowledge; clears rx_valid.
tx_data  in  8  byte to send.
tx_wr  in  1  1-cycle write of tx_data into the holder.
tx_empty  out  1  transmit holder empty.
frame_end  out  1  1-cycle pulse on a synchronised cs_n rise.
overrun  out  1  sticky: byte completed while rx_valid=1 and no rx_rd that cycle.
underrun  out  1  sticky: IDLE_BYTE substituted at a byte load.
clr_flags  in  1  clears overrun and underrun.

Behaviour:
- Reset values: spi_miso=1, spi_miso_oe=0, rx_data=0, rx_valid=0, tx_empty=1, frame_end=0, overrun=0, underrun=0, bit_cnt=0, state IDLE, armed=0.
- Inputs pass SYNC_STAGES flops. Edges are detected between the last synchroniser stage and one extra stage.
- `armed` sets when synchronised cs_n=1. A cs_n fall is acted on only when armed=1, so cs_n held low through reset release starts nothing until it goes high and then low.
- State IDLE → ACTIVE on a synchronised cs_n fall:
  - bit_cnt=0, reload=0.
  - tx_shift loads the holder and sets tx_empty=1; if the holder is empty, tx_shift loads IDLE_BYTE and sets underrun.
  - spi_miso=tx_shift[7], spi_miso_oe=1, all on the next fclk.
- ACTIVE, sck rise:
  - rx_shift <= {rx_shift[6:0], mosi}; bit_cnt <= bit_cnt+1 (3-bit wrap).
  - On the 8th rise (bit_cnt==7): rx_data <= {rx_shift[6:0], mosi}, rx_valid=1 on the next fclk, reload=1.
  - If rx_valid=1 and rx_rd is not asserted that cycle, set overrun; data is overwritten regardless.
- ACTIVE, sck fall:
  - If reload=1: tx_shift reloads exactly as at frame start, then reload=0.
  - Otherwise tx_shift <= tx_shift<<1.
  - spi_miso <= new tx_shift[7].
  - A fall before any rise is ignored.
- ACTIVE → IDLE on a synchronised cs_n rise, including mid-byte:
  - Partial rx bits are discarded; bit_cnt=0, reload=0.
  - spi_miso_oe=0, spi_miso=1, frame_end pulses.
  - The holder is retained; the byte already in tx_shift is lost.
- sck/mosi activity while IDLE is ignored.
- Timing:
  - Rx latency: rx_valid rises SYNC_STAGES+2 fclk after the 8th raw sck rise.
  - Miso changes SYNC_STAGES+2 fclk after the raw sck fall; the master samples on its next rise.
- Simultaneous events:
  - rx_rd coincident with byte completion: rx_valid stays 1, new data, no overrun.
  - tx_wr while the holder is full: overwrite, no flag.
  - tx_wr coincident with a reload from an empty holder: reload uses IDLE_BYTE and sets underrun; the written byte stays in the holder (tx_empty=0).
  - clr_flags coincident with a set: the set wins.
  - rx_rd with rx_valid=0: no effect.
- Asynchronous reset mid-frame returns every register to its reset value immediately.

Decomposition:
- Shared package: SPI_BITS=8, state encoding {IDLE, ACTIVE}, IDLE_BYTE default.
- One sub-module: spi_resp_sync, a parameterised multi-bit synchroniser plus rise/fall edge detector, instantiated once for 3 bits.
- The shift/holder logic stays in spi_resp.

Test Plan:
1. tx_wr 8'hA5 while IDLE, then a master sends 8'h3C at sck period 16 fclk → master reads 8'hA5; rx_data=8'h3C, rx_valid=1, tx_empty=1, no flags.
2. 3-byte frame 11/22/33, no tx_wr, rx_rd after each byte → master reads FF FF FF; underrun=1 after the first byte; overrun=0; frame_end pulses once.
3. Two bytes 55/AA with no rx_rd → rx_data=8'hAA, overrun=1; a later clr_flags clears it to 0.
4. cs_n rises after 5 bits of 8'hF0, then a new frame sends 8'h0F → rx_valid stays 0 until the second frame, then rx_data=8'h0F; miso_oe drops within SYNC_STAGES+2 fclk of the cs_n rise.
5. rx_rd coincident with completion of the second byte; separately, tx_wr coincident with a reload from an empty holder → no overrun; reload sends FF, underrun=1, tx_empty=0.
6. rst_n asserted mid-byte while cs_n stays low, released, then sck toggled → all outputs at reset values; no rx_valid until cs_n goes high then low.
